// File: rtl/irrigation_zone_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// irrigation_pkg
// Shared definitions for the multi-zone irrigation sequencer:
//   - state_e        : FSM state encoding, also exported on the 'state' port
//   - MODE_*         : run mode latched at the start of each irrigation run
//   - checkConflict  : detects physically impossible water-level readings
// ---------------------------------------------------------------------------
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        IRRIGATE = 3'd2,
        FAULT    = 3'd3
    } state_e;

    localparam logic MODE_DRIP      = 1'b0;
    localparam logic MODE_SPRINKLER = 1'b1;

    // A higher mark cannot be wet while a lower one is dry; either pattern
    // means a broken or stuck level sensor.
    function automatic logic checkConflict(input logic high, input logic mid, input logic low);
        return (high & ~mid) | (mid & ~low);
    endfunction

endpackage

// File: rtl/irrigation_zone_sequencer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock into a one-cycle 'tick' pulse every TICK_DIV
// cycles. Shared by the run countdown and the display countdown.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high; restarts the phase at count 0
//   tick   - high for one cycle when the count reaches TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // With TICK_DIV=1 LAST_COUNT is 0, so the count stays at 0 and tick is
    // permanently high.
    assign tick = (count_q == LAST_COUNT);

    // Wrap straight back to zero on the tick cycle.
    always_comb begin
        count_d = tick ? '0 : count_q + CW'(1);
    end

    // Counter register; reset restarts the phase so the first tick after
    // release comes a full TICK_DIV cycles later.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/irrigation_zone_sequencer.sv
// ---------------------------------------------------------------------------
// irrigation_zone_sequencer
// Scans ZONES soil sensors round-robin and opens one zone valve at a time for
// a timed run using either the sprinkler pump or the dripper. Also drives the
// tank refill valve with hysteresis and latches a fault on conflicting level
// sensors.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   enable                - system on; low returns the sequencer to IDLE
//   low/mid/high_water_level - tank level marks (1 = water at/above mark)
//   earth_humidity[ZONES] - per-zone soil sensor (0 = needs water)
//   air_humidity, low_temperature - weather inputs choosing run mode
//   zone_valve[ZONES]     - one-hot open zone valve, or all zero
//   splinker_bomb         - sprinkler pump on
//   dripper_valvule       - dripper on
//   water_supply_valvule  - refill valve open
//   alarm                 - alarm LED (fault or tank below mid)
//   active_zone           - zone pointer for the displays
//   remaining_time        - ticks left in the current run (0 outside runs)
//   state                 - FSM state code
// ---------------------------------------------------------------------------
module irrigation_zone_sequencer
    import irrigation_pkg::*;
#(
    parameter int ZONES          = 4,
    parameter int TIMER_WIDTH    = 8,
    parameter int SPRINKLER_TIME = 30,
    parameter int DRIP_TIME      = 60,
    parameter int TICK_DIV       = 1000,
    parameter int FAULT_HOLD     = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     low_water_level,
    input  logic                     mid_water_level,
    input  logic                     high_water_level,
    input  logic [ZONES-1:0]         earth_humidity,
    input  logic                     air_humidity,
    input  logic                     low_temperature,
    output logic [ZONES-1:0]         zone_valve,
    output logic                     splinker_bomb,
    output logic                     dripper_valvule,
    output logic                     water_supply_valvule,
    output logic                     alarm,
    output logic [$clog2(ZONES)-1:0] active_zone,
    output logic [TIMER_WIDTH-1:0]   remaining_time,
    output logic [2:0]               state
);

    localparam int PW = $clog2(ZONES);
    localparam int HW = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD) : 1;
    localparam logic [PW-1:0]          LAST_ZONE = PW'(ZONES - 1);
    localparam logic [HW-1:0]          HOLD_LAST = HW'(FAULT_HOLD - 1);
    localparam logic [TIMER_WIDTH-1:0] SPR_LOAD  = TIMER_WIDTH'(SPRINKLER_TIME);
    localparam logic [TIMER_WIDTH-1:0] DRIP_LOAD = TIMER_WIDTH'(DRIP_TIME);

    logic                   tick;
    logic                   conflict;
    logic                   sprinklerSel;
    logic                   zoneHumid;
    logic [PW-1:0]          nextPtr;

    state_e                 state_q, state_d;
    logic [PW-1:0]          zonePtr_q, zonePtr_d;
    logic [PW-1:0]          skipCnt_q, skipCnt_d;
    logic [TIMER_WIDTH-1:0] remTime_q, remTime_d;
    logic [HW-1:0]          holdCnt_q, holdCnt_d;
    logic                   mode_q, mode_d;
    logic                   supply_q, supply_d;
    logic [ZONES-1:0]       valve_q;
    logic                   sprinkler_q;
    logic                   dripper_q;
    logic                   alarm_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) uPrescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign conflict     = checkConflict(high_water_level, mid_water_level, low_water_level);
    assign sprinklerSel = ~air_humidity & ~low_temperature & mid_water_level;
    assign zoneHumid    = earth_humidity[zonePtr_q];
    assign nextPtr      = (zonePtr_q == LAST_ZONE) ? '0 : zonePtr_q + PW'(1);

    // Next-state logic. remaining_time and the fault-hold counter default
    // to zero so they are only non-zero while their own state holds them.
    // FAULT is latched: only a full conflict-free hold period releases it,
    // enable has no effect there.
    always_comb begin
        state_d   = state_q;
        zonePtr_d = zonePtr_q;
        skipCnt_d = skipCnt_q;
        remTime_d = '0;
        holdCnt_d = '0;
        mode_d    = mode_q;

        if (conflict) begin
            state_d = FAULT;
        end else if ((state_q != FAULT) && !enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SCAN;
                    skipCnt_d = '0;
                end
                SCAN: begin
                    if (!zoneHumid && low_water_level) begin
                        state_d   = IRRIGATE;
                        mode_d    = sprinklerSel ? MODE_SPRINKLER : MODE_DRIP;
                        remTime_d = sprinklerSel ? SPR_LOAD : DRIP_LOAD;
                        skipCnt_d = '0;
                    end else begin
                        zonePtr_d = nextPtr;
                        if (skipCnt_q == LAST_ZONE) begin
                            state_d   = IDLE;
                            skipCnt_d = '0;
                        end else begin
                            skipCnt_d = skipCnt_q + PW'(1);
                        end
                    end
                end
                IRRIGATE: begin
                    if (zoneHumid || !low_water_level ||
                        (tick && (remTime_q == TIMER_WIDTH'(1)))) begin
                        state_d   = SCAN;
                        zonePtr_d = nextPtr;
                    end else begin
                        remTime_d = tick ? remTime_q - TIMER_WIDTH'(1) : remTime_q;
                    end
                end
                FAULT: begin
                    if (tick) begin
                        if (holdCnt_q == HOLD_LAST) begin
                            state_d = IDLE;
                        end else begin
                            holdCnt_d = holdCnt_q + HW'(1);
                        end
                    end else begin
                        holdCnt_d = holdCnt_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Refill valve hysteresis: open below mid, close at high; a conflict or
    // the fault state always closes it.
    always_comb begin
        supply_d = supply_q;
        if (conflict || high_water_level || (state_q == FAULT)) begin
            supply_d = 1'b0;
        end else if (!mid_water_level) begin
            supply_d = 1'b1;
        end
    end

    // State and registered outputs. Valve outputs are derived from the
    // next-state values so they change on the same edge as the state,
    // which keeps the one-hot / pump-matches-valve invariant exact.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            zonePtr_q   <= '0;
            skipCnt_q   <= '0;
            remTime_q   <= '0;
            holdCnt_q   <= '0;
            mode_q      <= MODE_DRIP;
            supply_q    <= 1'b0;
            valve_q     <= '0;
            sprinkler_q <= 1'b0;
            dripper_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            zonePtr_q   <= zonePtr_d;
            skipCnt_q   <= skipCnt_d;
            remTime_q   <= remTime_d;
            holdCnt_q   <= holdCnt_d;
            mode_q      <= mode_d;
            supply_q    <= supply_d;
            valve_q     <= (state_d == IRRIGATE) ? (ZONES'(1) << zonePtr_d) : '0;
            sprinkler_q <= (state_d == IRRIGATE) && (mode_d == MODE_SPRINKLER);
            dripper_q   <= (state_d == IRRIGATE) && (mode_d == MODE_DRIP);
            alarm_q     <= (state_q == FAULT) | ~mid_water_level;
        end
    end

    assign zone_valve           = valve_q;
    assign splinker_bomb        = sprinkler_q;
    assign dripper_valvule      = dripper_q;
    assign water_supply_valvule = supply_q;
    assign alarm                = alarm_q;
    assign active_zone          = zonePtr_q;
    assign remaining_time       = remTime_q;
    assign state                = state_q;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irrigation_zone_sequencer
// Directed bench for irrigation_zone_sequencer with ZONES=4, TICK_DIV=1,
// SPRINKLER_TIME=3, DRIP_TIME=5, FAULT_HOLD=3. A table of hand-computed
// vectors covers scanning, drip and sprinkler runs, early run end, the
// all-skipped return to IDLE and the refill valve; hand-written sequences
// cover the fault hold and reset mid-run. A standalone TICK_DIV=3 prescaler
// shares the reset to show the phase restarting from zero.
// ---------------------------------------------------------------------------
module tb_irrigation_zone_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       lowLevel;
    logic       midLevel;
    logic       highLevel;
    logic [3:0] earthHumidity;
    logic       airHumidity;
    logic       lowTemperature;

    logic [3:0] zoneValve;
    logic       sprinklerPump;
    logic       dripper;
    logic       supplyValve;
    logic       alarmLed;
    logic [1:0] activeZone;
    logic [7:0] remainingTime;
    logic [2:0] stateCode;
    logic       refTick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic [2:0] lvl;
        logic [3:0] eh;
        logic       air;
        logic [2:0] st;
        logic [3:0] valve;
        logic       spr;
        logic       drp;
        logic       sup;
        logic       alm;
        logic [1:0] az;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs[$];

    irrigation_zone_sequencer #(
        .ZONES          (4),
        .TIMER_WIDTH    (8),
        .SPRINKLER_TIME (3),
        .DRIP_TIME      (5),
        .TICK_DIV       (1),
        .FAULT_HOLD     (3)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .enable               (enable),
        .low_water_level      (lowLevel),
        .mid_water_level      (midLevel),
        .high_water_level     (highLevel),
        .earth_humidity       (earthHumidity),
        .air_humidity         (airHumidity),
        .low_temperature      (lowTemperature),
        .zone_valve           (zoneValve),
        .splinker_bomb        (sprinklerPump),
        .dripper_valvule      (dripper),
        .water_supply_valvule (supplyValve),
        .alarm                (alarmLed),
        .active_zone          (activeZone),
        .remaining_time       (remainingTime),
        .state                (stateCode)
    );

    tick_prescaler #(
        .TICK_DIV (3)
    ) refPrescaler (
        .clock (clock),
        .reset (reset),
        .tick  (refTick)
    );

    // 10 ns system clock.
    always #5 clock = ~clock;

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic en, input logic [2:0] lvl, input logic [3:0] eh,
                                   input logic air, input logic [2:0] st, input logic [3:0] valve,
                                   input logic spr, input logic drp, input logic sup, input logic alm,
                                   input logic [1:0] az, input logic [7:0] rem);
        vec_t v;
        v.en = en; v.lvl = lvl; v.eh = eh; v.air = air;
        v.st = st; v.valve = valve; v.spr = spr; v.drp = drp;
        v.sup = sup; v.alm = alm; v.az = az; v.rem = rem;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs ({high,mid,low} packing for lvl), advance one edge and
    // settle 1 ns past it so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic en, input logic [2:0] lvl, input logic [3:0] eh,
                                 input logic air);
        enable         = en;
        highLevel      = lvl[2];
        midLevel       = lvl[1];
        lowLevel       = lvl[0];
        earthHumidity  = eh;
        airHumidity    = air;
        lowTemperature = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] st, input logic [3:0] valve,
                               input logic spr, input logic drp, input logic sup, input logic alm,
                               input logic [1:0] az, input logic [7:0] rem);
        checkVal({name, "/state"},  stateCode,     st);
        checkVal({name, "/valve"},  zoneValve,     valve);
        checkVal({name, "/spr"},    sprinklerPump, spr);
        checkVal({name, "/drip"},   dripper,       drp);
        checkVal({name, "/supply"}, supplyValve,   sup);
        checkVal({name, "/alarm"},  alarmLed,      alm);
        checkVal({name, "/zone"},   activeZone,    az);
        checkVal({name, "/rem"},    remainingTime, rem);
        checkVal({name, "/onehot"}, ($countones(zoneValve) <= 1) ? 1 : 0, 1);
        checkVal({name, "/pumpmatch"}, sprinklerPump | dripper, |zoneValve);
    endtask

    task automatic waitForState(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (stateCode !== target && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkVal(name, stateCode, target);
    endtask

    // Main stimulus: reset, table-driven vectors, then the fault and reset
    // corner cases.
    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        highLevel      = 1'b1;
        midLevel       = 1'b1;
        lowLevel       = 1'b1;
        earthHumidity  = 4'b1011;
        airHumidity    = 1'b1;
        lowTemperature = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset", 3'd0, 4'b0000, 0, 0, 0, 0, 2'd0, 8'd0);
        checkVal("reset/tick", refTick, 0);
        reset = 1'b0;

        // Drip run on zone 2 after skipping zones 0 and 1.
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd0, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd1, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd2, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd5);
        addVec(1, 3'b111, 4'b1011, 1, 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd4);
        addVec(1, 3'b111, 4'b1011, 1, 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd3);
        addVec(1, 3'b111, 4'b1011, 1, 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd2);
        addVec(1, 3'b111, 4'b1011, 1, 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd1);
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd3, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd0, 8'd0);
        // Sprinkler run; mid drops mid-run (levels 001), mode holds.
        addVec(1, 3'b111, 4'b1011, 0, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd1, 8'd0);
        addVec(1, 3'b111, 4'b1011, 0, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd2, 8'd0);
        addVec(1, 3'b111, 4'b1011, 0, 3'd2, 4'b0100, 1, 0, 0, 0, 2'd2, 8'd3);
        addVec(1, 3'b001, 4'b1011, 0, 3'd2, 4'b0100, 1, 0, 1, 1, 2'd2, 8'd2);
        addVec(1, 3'b001, 4'b1011, 0, 3'd2, 4'b0100, 1, 0, 1, 1, 2'd2, 8'd1);
        addVec(1, 3'b001, 4'b1011, 0, 3'd1, 4'b0000, 0, 0, 1, 1, 2'd3, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd0, 8'd0);
        // Run ended early by the soil becoming humid.
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd1, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd2, 8'd0);
        addVec(1, 3'b111, 4'b1011, 1, 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd5);
        addVec(1, 3'b111, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd3, 8'd0);
        // All humid: four skips then IDLE, pointer back where it began.
        addVec(1, 3'b111, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd0, 8'd0);
        addVec(1, 3'b111, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd1, 8'd0);
        addVec(1, 3'b111, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd2, 8'd0);
        addVec(1, 3'b111, 4'b1111, 1, 3'd0, 4'b0000, 0, 0, 0, 0, 2'd3, 8'd0);
        addVec(1, 3'b111, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd3, 8'd0);
        // Refill hysteresis: open below mid, hold at mid, close at high.
        addVec(1, 3'b001, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 1, 1, 2'd0, 8'd0);
        addVec(1, 3'b011, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 1, 0, 2'd1, 8'd0);
        addVec(1, 3'b111, 4'b1111, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 2'd2, 8'd0);
        // Empty tank: dry soil but no water, every zone skipped.
        addVec(1, 3'b000, 4'b0000, 1, 3'd0, 4'b0000, 0, 0, 1, 1, 2'd3, 8'd0);
        addVec(1, 3'b000, 4'b0000, 1, 3'd1, 4'b0000, 0, 0, 1, 1, 2'd3, 8'd0);
        addVec(1, 3'b000, 4'b0000, 1, 3'd1, 4'b0000, 0, 0, 1, 1, 2'd0, 8'd0);
        addVec(1, 3'b000, 4'b0000, 1, 3'd1, 4'b0000, 0, 0, 1, 1, 2'd1, 8'd0);
        addVec(1, 3'b000, 4'b0000, 1, 3'd1, 4'b0000, 0, 0, 1, 1, 2'd2, 8'd0);
        addVec(1, 3'b000, 4'b0000, 1, 3'd0, 4'b0000, 0, 0, 1, 1, 2'd3, 8'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].lvl, vecs[i].eh, vecs[i].air);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].valve, vecs[i].spr,
                        vecs[i].drp, vecs[i].sup, vecs[i].alm, vecs[i].az, vecs[i].rem);
        end

        // Fault: start a drip run on zone 2, then high-without-mid.
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("flt/scan", 3'd1, 4'b0000, 0, 0, 0, 0, 2'd3, 8'd0);
        waitForState(3'd2, 10, "flt/reachRun");
        checkVal("flt/runRem", remainingTime, 5);
        applyStimulus(1, 3'b100, 4'b1011, 1);
        checkOutput("flt/enter", 3'd3, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        // Two clean ticks with low-only level: supply stays forced closed.
        applyStimulus(1, 3'b001, 4'b1011, 1);
        checkOutput("flt/hold1", 3'd3, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        applyStimulus(1, 3'b001, 4'b1011, 1);
        checkOutput("flt/hold2", 3'd3, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        // Conflict at hold count 2 restarts the count.
        applyStimulus(1, 3'b100, 4'b1011, 1);
        checkOutput("flt/restart", 3'd3, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("flt/again1", 3'd3, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("flt/again2", 3'd3, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("flt/exit", 3'd0, 4'b0000, 0, 0, 0, 1, 2'd2, 8'd0);
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("flt/rescan", 3'd1, 4'b0000, 0, 0, 0, 0, 2'd2, 8'd0);

        // Reset mid-run with remaining_time=4.
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("rst/run5", 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd5);
        applyStimulus(1, 3'b111, 4'b1011, 1);
        checkOutput("rst/run4", 3'd2, 4'b0100, 0, 1, 0, 0, 2'd2, 8'd4);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rst/cleared", 3'd0, 4'b0000, 0, 0, 0, 0, 2'd0, 8'd0);
        checkVal("rst/phase0", refTick, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkVal("rst/phase1", refTick, 0);
        @(posedge clock);
        #1;
        checkVal("rst/phase2", refTick, 1);
        @(posedge clock);
        #1;
        checkVal("rst/phase3", refTick, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
